// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, prefetch FIFO, branch redirect.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_squash;
    logic          r_outstanding;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_instr [FIFO_DEPTH];
    logic [31:0]   r_mem_pc    [FIFO_DEPTH];

    logic          w_accept;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_used;
    logic          w_space;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_target;

    assign w_accept     = (r_state == ST_REQ) && imem_req_ready;
    assign w_rsp        = (r_state == ST_WAIT) && imem_rsp_valid;
    assign w_push       = w_rsp && !r_squash && !branch_taken;
    assign w_pop        = if_valid && if_ready && !branch_taken;
    assign w_used       = r_count + CW'(r_outstanding);
    assign w_space      = w_used < DEPTH_C;
    assign w_target     = branch_target & 32'hFFFF_FFFC;
    // A redirect flushes the FIFO and cancels any push/pop in the same cycle.
    assign w_count_next = branch_taken ? '0 : (r_count + CW'(w_push) - CW'(w_pop));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_space && !branch_taken) w_state_next = ST_REQ;
            ST_REQ: begin
                if (w_accept)          w_state_next = ST_WAIT;
                else if (branch_taken) w_state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (w_rsp) w_state_next = (w_count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_req_pc      <= '0;
            r_squash      <= 1'b0;
            r_outstanding <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            if (branch_taken)  r_pc <= w_target;
            else if (w_accept) r_pc <= r_pc + 32'd4;

            if (w_accept) r_req_pc <= r_pc;

            if (w_accept)   r_outstanding <= 1'b1;
            else if (w_rsp) r_outstanding <= 1'b0;

            // The one outstanding response clears squash whether or not it is dropped.
            if (w_rsp) r_squash <= 1'b0;
            else if (branch_taken && (w_accept || r_state == ST_WAIT)) r_squash <= 1'b1;

            if (branch_taken) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= imem_rsp_data;
                r_mem_pc[r_wr_ptr]    <= r_req_pc;
            end
        end
    end

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_addr      = r_pc;
    assign if_valid       = (r_count != '0);
    assign if_instr       = r_mem_instr[r_rd_ptr];
    assign if_pc          = r_mem_pc[r_rd_ptr];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_n;
    logic [32:0] w_flush_sum;

    // Discarded entries: FIFO contents plus an in-flight or just-accepted response.
    assign w_flush_n   = 32'(r_count) + 32'(r_outstanding || w_accept);
    assign w_flush_sum = {1'b0, r_perf_flushed} + {1'b0, w_flush_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_push && r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (branch_taken) r_perf_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle-latency instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic mem_auto;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    // Memory contents: instruction word = address ^ 0xA000_0000.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; memory answers an accepted request on the following cycle when mem_auto=1.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        branch_taken   = 1'b0;
        imem_rsp_valid = mem_auto && acc;
        imem_rsp_data  = acc ? instr_of(a) : 32'h0;
    endtask

    task automatic wait_next(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!if_valid && n < 10);
        chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        if_ready       = 1'b1;
        mem_auto       = 1'b1;
        tick();
        tick();

        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming fetch, memory always ready.
        rst_n = 1'b1;
        tick();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        wait_next("t1_first", n);
        chk("t1_first_latency_le4", 32'((n + 1) <= 4), 32'd1);
        chk("t1_pc0", if_pc, 32'h0000_0000);
        chk("t1_instr0", if_instr, 32'hA000_0000);
        wait_next("t1_second", n);
        chk("t1_pc4", if_pc, 32'h0000_0004);
        chk("t1_instr4", if_instr, 32'hA000_0004);
        wait_next("t1_third", n);
        chk("t1_pc8", if_pc, 32'h0000_0008);
        chk("t1_instr8", if_instr, 32'hA000_0008);

        // Decode stalled: two entries fill, then requests stop.
        if_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_full_if_valid", 32'(if_valid), 32'd1);
        chk("t2_head_pc", if_pc, 32'h0000_0000);
        chk("t2_head_instr", if_instr, 32'hA000_0000);
        if_ready = 1'b1;
        tick();
        chk("t2_pop2_valid", 32'(if_valid), 32'd1);
        chk("t2_pop2_pc", if_pc, 32'h0000_0004);
        chk("t2_pop2_instr", if_instr, 32'hA000_0004);
        tick();
        chk("t2_empty", 32'(if_valid), 32'd0);
        chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h0000_0008);

        // Redirect while a response is outstanding.
        mem_auto = 1'b0;
        do_reset();
        tick();
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        tick();
        chk("t3_wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t3_target_aligned", imem_addr, 32'h0000_0100);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000;
        tick();
        chk("t3_stale_dropped", 32'(if_valid), 32'd0);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_addr, 32'h0000_0100);
        mem_auto = 1'b1;
        wait_next("t3_deliver", n);
        chk("t3_pc", if_pc, 32'h0000_0100);
        chk("t3_instr", if_instr, 32'hA000_0100);

        // Redirect coinciding with request acceptance and a pop.
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        chk("t4_flushed", 32'(if_valid), 32'd0);
        chk("t4_in_wait", 32'(imem_req_valid), 32'd0);
        chk("t4_pc_target", imem_addr, 32'h0000_0200);
        tick();
        chk("t4_squash_dropped", 32'(if_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_addr, 32'h0000_0200);
        wait_next("t4_deliver", n);
        chk("t4_pc", if_pc, 32'h0000_0200);
        chk("t4_instr", if_instr, 32'hA000_0200);

        // PC wrap from the top of the address space.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        tick();
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
        wait_next("t5_top", n);
        chk("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        chk("t5_top_instr", if_instr, 32'h5FFF_FFFC);
        wait_next("t5_zero", n);
        chk("t5_zero_pc", if_pc, 32'h0000_0000);
        chk("t5_zero_instr", if_instr, 32'hA000_0000);

        // Reset while waiting; a late response must be ignored.
        mem_auto = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h0000_0000);
        tick();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD1_1111;
        tick();
        chk("t6_late_ignored", 32'(if_valid), 32'd0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0000_0000);
        mem_auto = 1'b1;
        wait_next("t6_deliver", n);
        chk("t6_pc", if_pc, 32'h0000_0000);
        chk("t6_instr", if_instr, 32'hA000_0000);

        // Redirect in REQ with the request not accepted: withdrawn, then reissued.
        imem_req_ready = 1'b0;
        branch_taken   = 1'b1;
        branch_target  = 32'h0000_0040;
        tick();
        chk("t7_withdrawn", 32'(imem_req_valid), 32'd0);
        chk("t7_flushed", 32'(if_valid), 32'd0);
        chk("t7_pc_target", imem_addr, 32'h0000_0040);
        tick();
        chk("t7_reissue_valid", 32'(imem_req_valid), 32'd1);
        chk("t7_reissue_addr", imem_addr, 32'h0000_0040);
        tick();
        chk("t7_hold_valid", 32'(imem_req_valid), 32'd1);
        chk("t7_hold_addr", imem_addr, 32'h0000_0040);
        imem_req_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
